// File: rtl/capture_seq.sv
// capture_seq: sample-buffer sequencer between the trigger/sampler path and
// the sample RAM / transmitter.
//   - While armed, writes samples into the RAM as a ring buffer.
//   - After run_i, counts dly_cnt post-trigger samples and then stops writing.
//   - Streams min(rd_cnt, 2**DEPTH) words to the transmitter, newest first.
// Ports:
//   clk_i, rst_i            clock, synchronous active-high reset
//   set_cnt_i, cmd_i        latch count fields: [15:0] read, [31:16] delay
//   arm_i, run_i, stb_i     start capture, trigger level, sample strobe
//   we_o, addr_o            RAM write enable and address
//   tx_rdy_i, tx_stb_o      transmitter idle / latch-read-data pulse
//   tx_sel_o                high while this block owns the transmitter
//   busy_o, done_o          not-idle flag, readout-complete pulse
module capture_seq #(
  parameter int unsigned DEPTH = 5,
  parameter int unsigned CW    = 18
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             set_cnt_i,
  input  logic [31:0]      cmd_i,
  input  logic             arm_i,
  input  logic             run_i,
  input  logic             stb_i,
  output logic             we_o,
  output logic [DEPTH-1:0] addr_o,
  input  logic             tx_rdy_i,
  output logic             tx_stb_o,
  output logic             tx_sel_o,
  output logic             busy_o,
  output logic             done_o
);

  localparam int unsigned NWORDS    = 2 ** DEPTH;
  localparam logic [CW-1:0] NWORDS_CW = CW'(NWORDS);
  localparam logic [CW-1:0] CNT_RST   = CW'(4);

  typedef enum logic [2:0] {
    ST_IDLE, ST_FILL, ST_DELAY, ST_FETCH, ST_SEND, ST_ADV
  } state_t;

  state_t           state_q, state_d;
  logic [DEPTH-1:0] wptr_q, wptr_d;
  logic [DEPTH-1:0] rptr_q, rptr_d;
  logic [CW-1:0]    dcnt_q, dcnt_d;
  logic [CW-1:0]    rem_q, rem_d;
  logic [CW-1:0]    rd_cnt_q, rd_cnt_d;
  logic [CW-1:0]    dly_cnt_q, dly_cnt_d;
  logic [CW-1:0]    rd_snap_q, rd_snap_d;
  logic [CW-1:0]    dly_snap_q, dly_snap_d;
  logic             done_q, done_d;

  logic [CW-1:0]    cmd_rd_scaled, cmd_dly_scaled, rd_eff;
  logic             we_c, tx_stb_c, readout_c;

  // Count fields are stored pre-scaled: (field + 1) * 4.
  assign cmd_rd_scaled  = CW'({17'(cmd_i[15:0])  + 17'd1, 2'b00});
  assign cmd_dly_scaled = CW'({17'(cmd_i[31:16]) + 17'd1, 2'b00});

  // Readout never exceeds the buffer size.
  assign rd_eff = (rd_snap_q > NWORDS_CW) ? NWORDS_CW : rd_snap_q;

  // Next-state and datapath updates.
  always_comb begin
    state_d    = state_q;
    wptr_d     = wptr_q;
    rptr_d     = rptr_q;
    dcnt_d     = dcnt_q;
    rem_d      = rem_q;
    rd_cnt_d   = rd_cnt_q;
    dly_cnt_d  = dly_cnt_q;
    rd_snap_d  = rd_snap_q;
    dly_snap_d = dly_snap_q;
    done_d     = 1'b0;
    we_c       = 1'b0;
    tx_stb_c   = 1'b0;

    if (set_cnt_i) begin
      rd_cnt_d  = cmd_rd_scaled;
      dly_cnt_d = cmd_dly_scaled;
    end

    unique case (state_q)
      ST_IDLE: begin
        if (arm_i) begin
          state_d    = ST_FILL;
          wptr_d     = '0;
          dcnt_d     = '0;
          rd_snap_d  = rd_cnt_q;
          dly_snap_d = dly_cnt_q;
        end
      end
      ST_FILL: begin
        we_c = stb_i;
        if (arm_i) begin
          // Re-arm restarts the ring from address 0.
          wptr_d     = '0;
          dcnt_d     = '0;
          rd_snap_d  = rd_cnt_q;
          dly_snap_d = dly_cnt_q;
        end else begin
          if (stb_i) wptr_d = wptr_q + DEPTH'(1);
          if (run_i) begin
            state_d = ST_DELAY;
            // A sample written in the trigger cycle is the first delay sample.
            dcnt_d  = stb_i ? CW'(1) : '0;
          end
        end
      end
      ST_DELAY: begin
        we_c = stb_i;
        if (stb_i) begin
          wptr_d = wptr_q + DEPTH'(1);
          dcnt_d = dcnt_q + CW'(1);
          if (dcnt_q + CW'(1) == dly_snap_q) begin
            state_d = ST_FETCH;
            rptr_d  = wptr_q;
            rem_d   = rd_eff;
          end
        end
      end
      ST_FETCH: state_d = ST_SEND;
      ST_SEND: begin
        if (tx_rdy_i) begin
          tx_stb_c = 1'b1;
          rem_d    = rem_q - CW'(1);
          rptr_d   = rptr_q - DEPTH'(1);
          state_d  = ST_ADV;
        end
      end
      ST_ADV: begin
        if (rem_q == '0) begin
          state_d = ST_IDLE;
          done_d  = 1'b1;
        end else begin
          state_d = ST_FETCH;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State and datapath registers.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q    <= ST_IDLE;
      wptr_q     <= '0;
      rptr_q     <= '0;
      dcnt_q     <= '0;
      rem_q      <= '0;
      rd_cnt_q   <= CNT_RST;
      dly_cnt_q  <= CNT_RST;
      rd_snap_q  <= CNT_RST;
      dly_snap_q <= CNT_RST;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      wptr_q     <= wptr_d;
      rptr_q     <= rptr_d;
      dcnt_q     <= dcnt_d;
      rem_q      <= rem_d;
      rd_cnt_q   <= rd_cnt_d;
      dly_cnt_q  <= dly_cnt_d;
      rd_snap_q  <= rd_snap_d;
      dly_snap_q <= dly_snap_d;
      done_q     <= done_d;
    end
  end

  assign readout_c = (state_q == ST_FETCH) || (state_q == ST_SEND) || (state_q == ST_ADV);

  // Reset suppresses strobes in its own cycle so an abort issues no more writes or sends.
  assign we_o     = we_c & ~rst_i;
  assign tx_stb_o = tx_stb_c & ~rst_i;
  assign tx_sel_o = readout_c;
  assign busy_o   = (state_q != ST_IDLE);
  assign done_o   = done_q;
  assign addr_o   = readout_c ? rptr_q : wptr_q;

endmodule

// File: tb/tb_capture_seq.sv
// Self-checking bench for capture_seq: table of capture scenarios plus
// hand-written sequences for reset defaults, handshake stall and abort.
module tb_capture_seq;
  localparam int unsigned DEPTH = 5;
  localparam int unsigned CW    = 18;

  logic             clk = 1'b0;
  logic             rst_i, set_cnt_i, arm_i, run_i, stb_i, tx_rdy_i;
  logic [31:0]      cmd_i;
  logic             we_o, tx_stb_o, tx_sel_o, busy_o, done_o;
  logic [DEPTH-1:0] addr_o;

  capture_seq #(.DEPTH(DEPTH), .CW(CW)) dut (
    .clk_i(clk), .rst_i(rst_i), .set_cnt_i(set_cnt_i), .cmd_i(cmd_i),
    .arm_i(arm_i), .run_i(run_i), .stb_i(stb_i), .we_o(we_o), .addr_o(addr_o),
    .tx_rdy_i(tx_rdy_i), .tx_stb_o(tx_stb_o), .tx_sel_o(tx_sel_o),
    .busy_o(busy_o), .done_o(done_o)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  logic [DEPTH-1:0] exp_q[$];
  int               n_tx, n_wr, n_done, cyc;
  int               tx_cyc_last, tx_cyc_prev;
  logic [DEPTH-1:0] last_waddr;

  typedef struct {
    logic [31:0] cmd;
    int          nfill;
    int          exp_writes;
    int          exp_start;
    int          exp_reads;
  } vec_t;
  vec_t vecs[4];

  task automatic chk(input string nm, input longint act, input longint exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  // Monitor samples mid-cycle, away from the active edge.
  always @(negedge clk) begin
    cyc++;
    if (tx_stb_o) begin
      n_tx++;
      tx_cyc_prev = tx_cyc_last;
      tx_cyc_last = cyc;
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL tx_unexpected: tx_stb_o at addr %0d with no expected word", addr_o);
      end else begin
        chk("tx_addr", longint'(addr_o), longint'(exp_q.pop_front()));
      end
    end
    if (we_o) begin
      n_wr++;
      last_waddr = addr_o;
    end
    if (done_o) begin
      n_done++;
      chk("done_sel_low", longint'(tx_sel_o), 0);
    end
  end

  task automatic step(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic clear_counts();
    n_tx = 0; n_wr = 0; n_done = 0;
  endtask

  task automatic push_reads(input int start, input int cnt);
    for (int i = 0; i < cnt; i++) exp_q.push_back(DEPTH'(start - i));
  endtask

  task automatic wait_done(input string nm);
    for (int k = 0; k < 3000 && n_done == 0; k++) step();
    if (n_done == 0) begin
      checks++;
      errors++;
      $display("FAIL %s_timeout: done_o not seen, got 0 expected 1", nm);
    end
    step(2);
  endtask

  // Default counts (4/4), run_i high from the arm cycle, stb every 'gap' cycles.
  task automatic seq_default(input string nm, input int gap);
    int nstb;
    clear_counts();
    push_reads(3, 4);
    tx_rdy_i = 1'b1;
    arm_i = 1'b1; run_i = 1'b1; step(); arm_i = 1'b0;
    nstb = 0;
    for (int k = 0; k < 50; k++) begin
      stb_i = 1'b1; step(); stb_i = 1'b0; nstb++;
      if (tx_sel_o) break;
      if (gap > 1) step(gap - 1);
    end
    run_i = 1'b0;
    wait_done(nm);
    chk({nm, "_stbs"}, nstb, 4);
    chk({nm, "_writes"}, n_wr, 4);
    chk({nm, "_last_waddr"}, longint'(last_waddr), 3);
    chk({nm, "_reads"}, n_tx, 4);
    chk({nm, "_done"}, n_done, 1);
    chk({nm, "_q_empty"}, exp_q.size(), 0);
  endtask

  initial begin
    rst_i = 1'b1; set_cnt_i = 1'b0; cmd_i = '0; arm_i = 1'b0; run_i = 1'b0;
    stb_i = 1'b0; tx_rdy_i = 1'b0;
    cyc = 0; tx_cyc_last = 0; tx_cyc_prev = 0; last_waddr = '0;
    clear_counts();

    vecs[0] = '{cmd: 32'h0001_0007, nfill: 40, exp_writes: 48, exp_start: 15, exp_reads: 32};
    vecs[1] = '{cmd: 32'h0000_00FF, nfill: 10, exp_writes: 14, exp_start: 13, exp_reads: 32};
    vecs[2] = '{cmd: 32'h0000_0002, nfill: 3,  exp_writes: 7,  exp_start: 6,  exp_reads: 12};
    vecs[3] = '{cmd: 32'h0002_0000, nfill: 0,  exp_writes: 12, exp_start: 11, exp_reads: 4};

    // Reset defaults.
    step(2);
    rst_i = 1'b0;
    chk("rst_we", longint'(we_o), 0);
    chk("rst_addr", longint'(addr_o), 0);
    chk("rst_tx_stb", longint'(tx_stb_o), 0);
    chk("rst_tx_sel", longint'(tx_sel_o), 0);
    chk("rst_busy", longint'(busy_o), 0);
    chk("rst_done", longint'(done_o), 0);

    // Default counts; trigger and first stb coincide in FILL.
    seq_default("dflt", 4);

    // Handshake stall: rd 16, dly 4.
    clear_counts();
    push_reads(3, 16);
    tx_rdy_i = 1'b0;
    cmd_i = 32'h0000_0003; set_cnt_i = 1'b1; step(); set_cnt_i = 1'b0;
    arm_i = 1'b1; step(); arm_i = 1'b0;
    run_i = 1'b1; stb_i = 1'b1; step(4); stb_i = 1'b0; run_i = 1'b0;
    chk("hs_fetch_sel", longint'(tx_sel_o), 1);
    step(11);
    chk("hs_stall_no_tx", n_tx, 0);
    chk("hs_stall_addr", longint'(addr_o), 3);
    chk("hs_stall_busy", longint'(busy_o), 1);
    tx_rdy_i = 1'b1;
    step(2);
    chk("hs_single_pulse", n_tx, 1);
    step(2);
    chk("hs_second_pulse", n_tx, 2);
    chk("hs_cadence", tx_cyc_last - tx_cyc_prev, 3);
    wait_done("hs");
    chk("hs_reads", n_tx, 16);
    chk("hs_done", n_done, 1);

    // Table-driven captures with ring wrap and read clamp.
    tx_rdy_i = 1'b1;
    foreach (vecs[v]) begin
      clear_counts();
      push_reads(vecs[v].exp_start, vecs[v].exp_reads);
      cmd_i = vecs[v].cmd; set_cnt_i = 1'b1; step(); set_cnt_i = 1'b0;
      arm_i = 1'b1; step(); arm_i = 1'b0;
      for (int i = 0; i < vecs[v].nfill; i++) begin
        stb_i = 1'b1; step(); stb_i = 1'b0; step();
      end
      run_i = 1'b1; step();
      for (int k = 0; k < 200; k++) begin
        stb_i = 1'b1; step(); stb_i = 1'b0;
        if (tx_sel_o) break;
        step();
      end
      run_i = 1'b0;
      wait_done($sformatf("vec%0d", v));
      chk($sformatf("vec%0d_writes", v), n_wr, vecs[v].exp_writes);
      chk($sformatf("vec%0d_last_waddr", v), longint'(last_waddr), vecs[v].exp_start);
      chk($sformatf("vec%0d_reads", v), n_tx, vecs[v].exp_reads);
      chk($sformatf("vec%0d_done", v), n_done, 1);
      chk($sformatf("vec%0d_busy", v), longint'(busy_o), 0);
    end

    // Abort during readout after 5 words.
    clear_counts();
    push_reads(3, 5);
    cmd_i = 32'h0000_0007; set_cnt_i = 1'b1; step(); set_cnt_i = 1'b0;
    arm_i = 1'b1; step(); arm_i = 1'b0;
    run_i = 1'b1; stb_i = 1'b1; step(4); stb_i = 1'b0; run_i = 1'b0;
    for (int k = 0; k < 200 && n_tx < 5; k++) step();
    chk("abort_sent", n_tx, 5);
    rst_i = 1'b1; step(); rst_i = 1'b0;
    chk("abort_tx_stb", longint'(tx_stb_o), 0);
    chk("abort_tx_sel", longint'(tx_sel_o), 0);
    chk("abort_busy", longint'(busy_o), 0);
    step(5);
    chk("abort_no_more_tx", n_tx, 5);
    chk("abort_no_done", n_done, 0);

    // Re-arm after abort starts from address 0 with reset counts.
    seq_default("rearm", 1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
